// File: rtl/dtb_pkg.sv
// rtl/dtb_pkg.sv - shared trace buffer parameters and serializer state encoding
//
// Purpose: word/lane sizing shared between the trace buffer and its FPGA-side
// feeders, plus the trace_serializer state enum.
// Contents:
//   TRB_WIDTH        trace word width
//   TRB_MAX_TRACES   physical trace lane count
//   TRB_NTRACE_BITS  width of the lane-count exponent port
//   trs_state_e      trace_serializer FSM states
package dtb_pkg;

  localparam int TRB_WIDTH       = 32;
  localparam int TRB_MAX_TRACES  = 8;
  localparam int TRB_NTRACE_BITS = $clog2($clog2(TRB_MAX_TRACES) + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } trs_state_e;

endpackage

// File: rtl/trace_serializer.sv
// rtl/trace_serializer.sv - word-to-lane transmitter feeding the trace buffer
//
// Purpose: accepts whole trace words over ready/valid and emits them as
// 2**num_traces_i-bit beats on trace_o, advancing only while write_en_i is high.
// A trigger tag travels with each word and is held for all of its beats.
// Optional feature macro: TRACE_SERIALIZER_MSB_FIRST_EN (most-significant chunk
// first; default is least-significant chunk first, matching the deserializer).
// Ports:
//   clk_i          FPGA clock, rising edge
//   rst_ni         synchronous active-low reset
//   num_traces_i   lane-count exponent, clamped to log2(MAX_TRACES)
//   data_valid_i   word valid
//   data_ready_o   word accepted when valid && ready (combinational)
//   data_i         trace word
//   trig_i         trigger tag, sampled with data_i
//   write_en_i     buffer consumes the current beat this cycle
//   trace_o        current beat, unused upper lanes 0 (registered)
//   trig_o         trigger tag of the word in flight (registered)
//   busy_o         a word is being shifted out (registered)
module trace_serializer
  import dtb_pkg::*;
#(
  parameter int WIDTH      = TRB_WIDTH,
  parameter int MAX_TRACES = TRB_MAX_TRACES
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [TRB_NTRACE_BITS-1:0] num_traces_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       trig_i,
  input  logic                       write_en_i,
  output logic [MAX_TRACES-1:0]      trace_o,
  output logic                       trig_o,
  output logic                       busy_o
);

  localparam int LOG_MAX = $clog2(MAX_TRACES);
  localparam int CNT_W   = $clog2(WIDTH);

  trs_state_e                 state_q, state_d;
  logic [WIDTH-1:0]           word_q, word_d;
  logic                       trig_q, trig_d;
  logic [TRB_NTRACE_BITS-1:0] exp_q, exp_d;
  logic [CNT_W-1:0]           beat_q, beat_d;
  logic [MAX_TRACES-1:0]      trace_q, trace_d;

  logic                       ready;
  logic                       load;
  logic [CNT_W-1:0]           last_beat;
  logic [TRB_NTRACE_BITS-1:0] exp_in;
  logic [WIDTH-1:0]           shifted;
  int                         lanes_d;
  int                         shamt;

  assign last_beat = CNT_W'((WIDTH >> exp_q) - 1);
  assign exp_in    = (int'(num_traces_i) > LOG_MAX) ? TRB_NTRACE_BITS'(LOG_MAX) : num_traces_i;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    trig_d  = trig_q;
    exp_d   = exp_q;
    beat_d  = beat_q;
    ready   = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (data_valid_i) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (write_en_i) begin
          if (beat_q == last_beat) begin
            // Last beat leaves this cycle: a waiting word loads with no gap beat.
            ready = 1'b1;
            if (data_valid_i) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              trig_d  = 1'b0;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      word_d = data_i;
      trig_d = trig_i;
      exp_d  = exp_in;
      beat_d = '0;
    end

    // Outputs are registered, so the beat for next cycle is built from next-state.
    lanes_d = 1 << exp_d;
`ifdef TRACE_SERIALIZER_MSB_FIRST_EN
    shamt = WIDTH - (int'(beat_d) + 1) * lanes_d;
`else
    shamt = int'(beat_d) * lanes_d;
`endif
    shifted = word_d >> shamt;
    trace_d = '0;
    if (state_d == ST_SHIFT) begin
      for (int l = 0; l < MAX_TRACES; l++) begin
        if (l < lanes_d) trace_d[l] = shifted[l];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      trig_q  <= 1'b0;
      exp_q   <= '0;
      beat_q  <= '0;
      trace_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      trig_q  <= trig_d;
      exp_q   <= exp_d;
      beat_q  <= beat_d;
      trace_q <= trace_d;
    end
  end

  // Gated by reset so ready reads 0 while reset is held, whatever the state.
  assign data_ready_o = rst_ni & ready;
  assign trace_o      = trace_q;
  assign trig_o       = trig_q;
  assign busy_o       = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_trace_serializer.sv
// tb/tb_trace_serializer.sv - self-checking bench for trace_serializer
module tb_trace_serializer;
  import dtb_pkg::*;

  logic                       clk = 1'b0;
  logic                       rstn = 1'b0;
  logic [TRB_NTRACE_BITS-1:0] num_traces = '0;
  logic                       valid = 1'b0;
  logic                       ready;
  logic [31:0]                data = '0;
  logic                       trig = 1'b0;
  logic                       we = 1'b1;
  logic [7:0]                 trace_o;
  logic                       trig_o;
  logic                       busy;

  always #5 clk = ~clk;

  trace_serializer #(.WIDTH(32), .MAX_TRACES(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rstn),
    .num_traces_i (num_traces),
    .data_valid_i (valid),
    .data_ready_o (ready),
    .data_i       (data),
    .trig_i       (trig),
    .write_en_i   (we),
    .trace_o      (trace_o),
    .trig_o       (trig_o),
    .busy_o       (busy)
  );

  typedef struct {
    logic [7:0] trace;
    logic       trig;
    logic       last;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    int          nt;
    logic        trig;
    int          we_mode;
  } vec_t;

  beat_t sb[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    we_mode = 0;
  bit    mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_beat(input logic [31:0] w, input int nt, input int k);
    int          lanes;
    int          sh;
    logic [31:0] v;
    lanes = 1 << ((nt > 3) ? 3 : nt);
`ifdef TRACE_SERIALIZER_MSB_FIRST_EN
    sh = 32 - (k + 1) * lanes;
`else
    sh = k * lanes;
`endif
    v = (w >> sh) & ((32'd1 << lanes) - 32'd1);
    return v[7:0];
  endfunction

  // write-enable pattern generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (we_mode)
        0: we = 1'b1;
        1: we = ~we;
        2: we = 1'($urandom_range(0, 1));
        default: we = 1'b0;
      endcase
    end
  end

  // scoreboard monitor: every busy cycle must show the expected beat
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rstn) begin
        if (busy) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_beat: got trace 0x%0h, expected no word in flight", trace_o);
          end else begin
            check("beat_trace", 32'(trace_o), 32'(sb[0].trace));
            check("beat_trig", 32'(trig_o), 32'(sb[0].trig));
            check("beat_ready", 32'(ready), 32'(sb[0].last && we));
            if (we) void'(sb.pop_front());
          end
        end else begin
          check("idle_trace", 32'(trace_o), 32'h0);
          check("idle_trig", 32'(trig_o), 32'h0);
          check("idle_ready", 32'(ready), 32'h1);
        end
      end
    end
  end

  // Drive a word, wait (bounded) for acceptance, then push its expected beats.
  task automatic send_word(input logic [31:0] w, input int nt, input logic tg);
    int lanes;
    int nb;
    data       = w;
    num_traces = TRB_NTRACE_BITS'(nt);
    trig       = tg;
    valid      = 1'b1;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (ready) break;
      if (c >= 400) begin
        n_vec++;
        n_bad++;
        $display("FAIL accept_timeout: got no ready, expected accept of 0x%0h", w);
        @(posedge clk);
        #1;
        valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    lanes = 1 << ((nt > 3) ? 3 : nt);
    nb    = 32 / lanes;
    for (int k = 0; k < nb; k++) sb.push_back('{model_beat(w, nt, k), tg, (k == nb - 1)});
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 2000; c++) begin
      if (sb.size() == 0 && !busy) break;
      @(negedge clk);
    end
    check("drain_empty", 32'(sb.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  vec_t        tbl[7];
  logic [7:0]  exp_bytes[4];

  initial begin
    tbl[0] = '{32'h00000005, 0, 1'b0, 0};
    tbl[1] = '{32'hAABBCCDD, 3, 1'b0, 1};
    tbl[2] = '{32'hDEADBEEF, 2, 1'b1, 2};
    tbl[3] = '{32'h12345678, 1, 1'b0, 0};
    tbl[4] = '{32'hCAFEF00D, 7, 1'b1, 0};
    tbl[5] = '{32'h0F0F0F0F, 2, 1'b0, 2};
    tbl[6] = '{32'hFFFFFFFF, 0, 1'b1, 2};
`ifdef TRACE_SERIALIZER_MSB_FIRST_EN
    exp_bytes = '{8'h87, 8'h65, 8'h43, 8'h21};
`else
    exp_bytes = '{8'h21, 8'h43, 8'h65, 8'h87};
`endif

    // reset values
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_trace", 32'(trace_o), 32'h0);
    check("rst_trig", 32'(trig_o), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(ready), 32'h1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // first-beat latency and byte order with constant expectations
    we_mode = 0;
    send_word(32'h87654321, 3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("byte_order_%0d", k), 32'(trace_o), 32'(exp_bytes[k]));
    end
    drain();

    // table-driven words
    for (int i = 0; i < 7; i++) begin
      we_mode = tbl[i].we_mode;
      send_word(tbl[i].data, tbl[i].nt, tbl[i].trig);
      drain();
    end
    we_mode = 0;
    drain();

    // back-to-back words 0..3, trigger only on word 2 (beats 8..11)
    fork
      begin
        for (int i = 0; i < 4; i++) send_word(32'(i), 3, (i == 2));
      end
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (busy) break;
        end
        for (int k = 0; k < 16; k++) begin
          check($sformatf("gapless_busy_%0d", k), 32'(busy), 32'h1);
          check($sformatf("gapless_trig_%0d", k), 32'(trig_o), 32'((k >= 8) && (k <= 11)));
          if (k < 15) @(negedge clk);
        end
      end
    join
    drain();

    // lane count changes mid-word: current word keeps 8 lanes, next uses 2
    send_word(32'h11223344, 3, 1'b0);
    num_traces = 2'd1;
    drain();
    send_word(32'h55667788, 1, 1'b0);
    drain();

    // write enable held low: word holds indefinitely
    we_mode = 3;
    send_word(32'h0BADC0DE, 3, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    we_mode = 0;
    drain();

    // reset while beat 2 is on the lanes
    send_word(32'h87654321, 3, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_trace", 32'(trace_o), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_trig", 32'(trig_o), 32'h0);
    check("midrst_ready", 32'(ready), 32'h0);
    sb.delete();
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_ready_release", 32'(ready), 32'h1);
    @(posedge clk);
    #1;
    send_word(32'hA1B2C3D4, 3, 1'b0);
    @(negedge clk);
    check("post_rst_beat0", 32'(trace_o), 32'(model_beat(32'hA1B2C3D4, 3, 0)));
    drain();

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
